// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the UART hex calculator datapath.
//
// Contents:
//   state_e        - sequencing states of the multi-cycle add/subtract unit
//   OP_ADD/OP_SUB  - opcode encodings delivered by the command parser
package calc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage : calc_pkg

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple-carry adder slice.
//
// Parameters:
//   CHUNK  - slice width in bits
//   MSB_EN - 1: c_msb reports the carry into the top bit; 0: c_msb is held low
//            so no downstream overflow logic is generated
// Ports:
//   a, b   in  CHUNK  addends (b is already inverted by the caller for subtract)
//   c_in   in  1      carry in
//   sum    out CHUNK  sum bits
//   c_out  out 1      carry out of the top bit
//   c_msb  out 1      carry into the top bit (signed-overflow detection)
module addsub_chunk #(
   parameter int CHUNK  = 4,
   parameter bit MSB_EN = 1'b1
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] sum,
   output logic             c_out,
   output logic             c_msb
);

   // carry[i] is the carry into bit i; carry[CHUNK] leaves the slice.
   logic [CHUNK:0] carry;

   assign carry[0] = c_in;

   generate
      for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
         assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
         assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign c_out = carry[CHUNK];

   generate
      if (MSB_EN) begin : g_msb
         assign c_msb = carry[CHUNK-1];
      end else begin : g_no_msb
         assign c_msb = 1'b0;
      end
   endgenerate

endmodule : addsub_chunk

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock.
//
// Build option: define ADDSUB_SEQ_OVF_EN to compute the signed-overflow flag;
// without it ovf is constant 0 and no MSB-carry logic exists.
//
// Parameters: WIDTH (operand width, multiple of CHUNK), CHUNK (bits per cycle)
// Ports:
//   clk     in  1      clock, rising edge
//   rst_n   in  1      asynchronous active-low reset
//   start   in  1      request, accepted in IDLE or DONE only
//   op      in  1      0 = a+b, 1 = a-b
//   a, b    in  WIDTH  operands, captured on accepted start
//   busy    out 1      chunks being processed
//   done    out 1      one-cycle pulse, result and flags valid
//   result  out WIDTH  sum/difference modulo 2^WIDTH
//   c_out   out 1      carry out of MSB (subtract: 1 = no borrow)
//   zero    out 1      result == 0
//   ovf     out 1      signed overflow
module addsub_seq
   import calc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             zero,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

`ifdef ADDSUB_SEQ_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   state_e           state_q,  state_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic             carry_q,  carry_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             c_out_q,  c_out_d;
   logic             zero_q,   zero_d;
`ifdef ADDSUB_SEQ_OVF_EN
   logic             ovf_q,    ovf_d;
`endif

   logic [CHUNK-1:0] chunk_sum;
   logic             chunk_co;
   logic             chunk_cmsb;

   // Operands shift right by CHUNK each busy cycle, so the active chunk is
   // always the low slice and the single adder needs no input mux.
   addsub_chunk #(
      .CHUNK  (CHUNK),
      .MSB_EN (OVF_EN)
   ) u_chunk (
      .a     (a_q[CHUNK-1:0]),
      .b     (b_q[CHUNK-1:0]),
      .c_in  (carry_q),
      .sum   (chunk_sum),
      .c_out (chunk_co),
      .c_msb (chunk_cmsb)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      c_out_d  = c_out_q;
      zero_d   = zero_q;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_d    = ovf_q;
`endif

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d     = a;
               // Subtract as a + ~b + 1: the +1 enters through the carry reg.
               b_d     = (op == OP_SUB) ? ~b : b;
               carry_d = op;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_BUSY: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            carry_d = chunk_co;
            cnt_d   = cnt_q + CW'(1);
            for (int k = 0; k < NCHUNK; k++) begin
               if (cnt_q == CW'(k)) begin
                  result_d[k*CHUNK +: CHUNK] = chunk_sum;
               end
            end
            if (cnt_q == CW'(NCHUNK - 1)) begin
               cnt_d   = '0;
               c_out_d = chunk_co;
               zero_d  = (result_d == '0);
`ifdef ADDSUB_SEQ_OVF_EN
               ovf_d   = chunk_co ^ chunk_cmsb;
`endif
               state_d = ST_DONE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         zero_q   <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
         zero_q   <= zero_d;
`ifdef ADDSUB_SEQ_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy   = (state_q == ST_BUSY);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign c_out  = c_out_q;
   assign zero   = zero_q;
`ifdef ADDSUB_SEQ_OVF_EN
   assign ovf    = ovf_q;
`else
   // The slice is built with MSB_EN = 0, so this is a constant low.
   assign ovf    = chunk_cmsb;
`endif

endmodule : addsub_seq

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed self-checking bench for addsub_seq (WIDTH 16, CHUNK 4).
module tb_addsub_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        op;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        c_out;
   logic        zero;
   logic        ovf;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef ADDSUB_SEQ_OVF_EN
   localparam logic OVF_BUILD = 1'b1;
`else
   localparam logic OVF_BUILD = 1'b0;
`endif

   addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .c_out  (c_out),
      .zero   (zero),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation: busy for 4 cycles, done on the 5th, then flags.
   task automatic run_op(input string name, input logic o, input logic [15:0] va,
                         input logic [15:0] vb, input logic [15:0] exp_res,
                         input logic exp_c, input logic exp_z, input logic exp_v);
      start = 1'b1; op = o; a = va; b = vb;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk({name, " busy"}, {15'd0, busy}, 16'd1);
         chk({name, " done_early"}, {15'd0, done}, 16'd0);
         tick();
      end
      chk({name, " done"}, {15'd0, done}, 16'd1);
      chk({name, " busy_in_done"}, {15'd0, busy}, 16'd0);
      chk({name, " result"}, result, exp_res);
      chk({name, " c_out"}, {15'd0, c_out}, {15'd0, exp_c});
      chk({name, " zero"}, {15'd0, zero}, {15'd0, exp_z});
      chk({name, " ovf"}, {15'd0, ovf}, {15'd0, exp_v & OVF_BUILD});
      $display("[TB] op=%0d a=%h b=%h -> result=%h c=%0d z=%0d v=%0d",
               o, va, vb, result, c_out, zero, ovf);
      tick();
      chk({name, " done_pulse"}, {15'd0, done}, 16'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      #12;
      chk("rst result", result, 16'h0000);
      chk("rst flags", {12'd0, busy, done, c_out, zero}, 16'd0);
      chk("rst ovf", {15'd0, ovf}, 16'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      run_op("add",     1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);
      run_op("sub_brw", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      run_op("ovf_add", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);
      run_op("ovf_sub", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1);
      run_op("sub_eq",  1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0);
      run_op("wrap",    1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);

      // Busy interlock: start re-asserted mid-operation must be ignored.
      start = 1'b1; op = 1'b0; a = 16'h0001; b = 16'h0001;
      tick();                      // E0 accepted
      start = 1'b0;
      tick();                      // E1
      chk("lock busy1", {15'd0, busy}, 16'd1);
      start = 1'b1; a = 16'hFFFF;
      tick();                      // E2
      chk("lock busy2", {14'd0, busy, done}, 16'b10);
      tick();                      // E3
      chk("lock busy3", {14'd0, busy, done}, 16'b10);
      start = 1'b0;
      tick();                      // E4 -> done
      chk("lock done", {14'd0, busy, done}, 16'b01);
      chk("lock result", result, 16'h0002);
      $display("[TB] interlock 0001+0001 (start during busy) -> result=%h", result);
      // Back-to-back start during done.
      start = 1'b1; op = 1'b1; a = 16'h0010; b = 16'h0001;
      tick();                      // E5 accepted
      start = 1'b0;
      chk("b2b busy", {14'd0, busy, done}, 16'b10);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("b2b no_done", {15'd0, done}, 16'd0);
      end
      tick();                      // E9 -> done
      chk("b2b done", {14'd0, busy, done}, 16'b01);
      chk("b2b result", result, 16'h000F);
      chk("b2b c_out", {15'd0, c_out}, 16'd1);
      $display("[TB] back-to-back 0010-0001 -> result=%h c=%0d", result, c_out);
      tick();

      // Reset mid-operation.
      start = 1'b1; op = 1'b0; a = 16'hFFFF; b = 16'h0001;
      tick();
      start = 1'b0;
      tick();
      chk("mid busy", {15'd0, busy}, 16'd1);
      rst_n = 1'b0;
      #1;
      chk("mid rst result", result, 16'h0000);
      chk("mid rst flags", {11'd0, busy, done, c_out, zero, ovf}, 16'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post rst idle", {14'd0, busy, done}, 16'd0);
      end
      $display("[TB] reset mid-operation -> busy=%0d done=%0d result=%h", busy, done, result);
      run_op("post_rst", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_addsub_seq
